// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter.
// Shares the single register-file write port between ALU (A) and load (M)
// writeback requesters. Uses a valid/ready handshake with round-robin
// priority and a one-stage registered write output. Writes to x0 are
// dropped, and RAW hazards are flagged on rs1/rs2.
module regfile_wb_arbiter #(
   parameter int unsigned REGF_WIDTH = 32,
   parameter int unsigned SELECTORS  = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  a_valid,
   input  logic [SELECTORS-1:0]  a_sel,
   input  logic [REGF_WIDTH-1:0] a_data,
   output logic                  a_ready,
   input  logic                  m_valid,
   input  logic [SELECTORS-1:0]  m_sel,
   input  logic [REGF_WIDTH-1:0] m_data,
   output logic                  m_ready,
   input  logic [SELECTORS-1:0]  rs1,
   input  logic [SELECTORS-1:0]  rs2,
   output logic [SELECTORS-1:0]  rsW,
   output logic [REGF_WIDTH-1:0] rd,
   output logic                  RegWEn,
   output logic                  rs1_pending,
   output logic                  rs2_pending
);

   typedef enum logic {
      PRIO_A = 1'b0,
      PRIO_M = 1'b1
   } prio_t;

   prio_t                 r_prio;
   prio_t                 w_prio_next;
   logic                  w_xfer;
   logic [SELECTORS-1:0]  w_grant_sel;
   logic [REGF_WIDTH-1:0] w_grant_data;

   logic                  r_regwen;
   logic [SELECTORS-1:0]  r_rsw;
   logic [REGF_WIDTH-1:0] r_rd;

   // Priority pointer register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prio <= PRIO_A;
      end else begin
         r_prio <= w_prio_next;
      end
   end

   // Round-robin grant, handshake readies and pointer next-state
   always_comb begin
      a_ready      = 1'b0;
      m_ready      = 1'b0;
      w_prio_next  = r_prio;
      w_xfer       = 1'b0;
      w_grant_sel  = a_sel;
      w_grant_data = a_data;
      if (!rst) begin
         a_ready = !m_valid || (r_prio == PRIO_A);
         m_ready = !a_valid || (r_prio == PRIO_M);
         // At most one of these can fire: with both valid only one ready is high
         if (a_valid && a_ready) begin
            w_xfer      = 1'b1;
            w_prio_next = PRIO_M;
         end else if (m_valid && m_ready) begin
            w_xfer       = 1'b1;
            w_prio_next  = PRIO_A;
            w_grant_sel  = m_sel;
            w_grant_data = m_data;
         end
      end
   end

   // Registered write stage; x0 writes complete the handshake but never enable
   always_ff @(posedge clk) begin
      if (rst) begin
         r_regwen <= 1'b0;
         r_rsw    <= '0;
         r_rd     <= '0;
      end else begin
         r_regwen <= w_xfer && (w_grant_sel != '0);
         if (w_xfer) begin
            r_rsw <= w_grant_sel;
            r_rd  <= w_grant_data;
         end
      end
   end

   // Hazard flags: write in flight in the output stage or still being requested
   always_comb begin
      rs1_pending = (rs1 != '0) &&
                    ((r_regwen && (r_rsw == rs1)) ||
                     (a_valid && (a_sel == rs1)) ||
                     (m_valid && (m_sel == rs1)));
      rs2_pending = (rs2 != '0) &&
                    ((r_regwen && (r_rsw == rs2)) ||
                     (a_valid && (a_sel == rs2)) ||
                     (m_valid && (m_sel == rs2)));
   end

   assign rsW    = r_rsw;
   assign rd     = r_rd;
   assign RegWEn = r_regwen;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed plan items followed by
// randomized traffic against a behavioural model and a register-file scoreboard.
module tb_regfile_wb_arbiter;

   localparam int unsigned W = 32;
   localparam int unsigned S = 5;
   localparam int unsigned NREG = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         a_valid, m_valid;
   logic [S-1:0] a_sel, m_sel, rs1, rs2, rsW;
   logic [W-1:0] a_data, m_data, rd;
   logic         a_ready, m_ready, RegWEn, rs1_pending, rs2_pending;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.REGF_WIDTH(W), .SELECTORS(S)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_sel(a_sel), .a_data(a_data), .a_ready(a_ready),
      .m_valid(m_valid), .m_sel(m_sel), .m_data(m_data), .m_ready(m_ready),
      .rs1(rs1), .rs2(rs2),
      .rsW(rsW), .rd(rd), .RegWEn(RegWEn),
      .rs1_pending(rs1_pending), .rs2_pending(rs2_pending)
   );

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model state: whose turn it is, and the write waiting to land
   bit           mdl_turn_m;
   bit           mdl_wen;
   logic [S-1:0] mdl_sel;
   logic [W-1:0] mdl_data;
   bit           mdl_known = 1'b0;
   bit           last_af, last_mf;
   logic [W-1:0] rf_exp [NREG];
   logic [W-1:0] rf_dut [NREG];

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit mdl_pend(input logic [S-1:0] rs, input bit av, input logic [S-1:0] as,
                                   input bit mv, input logic [S-1:0] ms);
      if (rs == '0) return 1'b0;
      return (mdl_wen && mdl_sel == rs) || (av && as == rs) || (mv && ms == rs);
   endfunction

   // One clock cycle: drive inputs, check against model, then advance model
   task automatic cycle(input bit r, input bit av, input logic [S-1:0] as, input logic [W-1:0] ad,
                        input bit mv, input logic [S-1:0] ms, input logic [W-1:0] md,
                        input logic [S-1:0] r1, input logic [S-1:0] r2);
      bit ear, emr;
      @(negedge clk);
      rst = r; a_valid = av; a_sel = as; a_data = ad;
      m_valid = mv; m_sel = ms; m_data = md; rs1 = r1; rs2 = r2;
      #1;
      ear = !r && (!mv || !mdl_turn_m);
      emr = !r && (!av || mdl_turn_m);
      chk("a_ready", W'(a_ready), W'(ear));
      chk("m_ready", W'(m_ready), W'(emr));
      if (mdl_known) begin
         chk("RegWEn", W'(RegWEn), W'(mdl_wen));
         chk("rsW", W'(rsW), W'(mdl_sel));
         chk("rd", rd, mdl_data);
         chk("rs1_pending", W'(rs1_pending), W'(mdl_pend(r1, av, as, mv, ms)));
         chk("rs2_pending", W'(rs2_pending), W'(mdl_pend(r2, av, as, mv, ms)));
         if (mdl_wen) rf_exp[mdl_sel] = mdl_data;
      end
      if (RegWEn === 1'b1) rf_dut[rsW] = rd;
      last_af = av && ear;
      last_mf = mv && emr;
      if (r) begin
         mdl_turn_m = 1'b0; mdl_wen = 1'b0; mdl_sel = '0; mdl_data = '0; mdl_known = 1'b1;
      end else if (last_af) begin
         mdl_turn_m = 1'b1; mdl_wen = (as != '0); mdl_sel = as; mdl_data = ad;
      end else if (last_mf) begin
         mdl_turn_m = 1'b0; mdl_wen = (ms != '0); mdl_sel = ms; mdl_data = md;
      end else begin
         mdl_wen = 1'b0;
      end
   endtask

   task automatic idle(input logic [S-1:0] r1, input logic [S-1:0] r2);
      cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, r1, r2);
   endtask

   initial begin
      bit           av, mv;
      logic [S-1:0] as, ms;
      logic [W-1:0] ad, md;
      bit           r;
      int           ga, gm;

      for (int i = 0; i < int'(NREG); i++) begin
         rf_exp[i] = '0;
         rf_dut[i] = '0;
      end

      // Reset for two cycles with both requesters asserting valid
      cycle(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, '0, '0);
      cycle(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, '0, '0);
      chk("rst_a_ready", W'(a_ready), '0);
      chk("rst_m_ready", W'(m_ready), '0);
      chk("rst_RegWEn", W'(RegWEn), '0);
      chk("rst_rsW", W'(rsW), '0);
      chk("rst_rd", rd, '0);

      // Single requester
      cycle(1'b0, 1'b1, 5'd3, 32'hFFFF_00FF, 1'b0, '0, '0, '0, '0);
      chk("single_a_ready", W'(a_ready), W'(1));
      idle('0, '0);
      chk("single_wen", W'(RegWEn), W'(1));
      chk("single_rsW", W'(rsW), W'(3));
      chk("single_rd", rd, 32'hFFFF_00FF);
      idle('0, '0);
      chk("single_wen_off", W'(RegWEn), '0);

      // x0 drop from M: handshake completes, no write, turn returns to A
      cycle(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 32'hDEAD_BEEF, '0, '0);
      chk("x0_m_ready", W'(m_ready), W'(1));

      // Contention: A wins first (turn is A after the x0 grant), then M
      cycle(1'b0, 1'b1, 5'd5, 32'h1111_1111, 1'b1, 5'd6, 32'h2222_2222, '0, '0);
      chk("x0_no_wen", W'(RegWEn), '0);
      chk("cont0_a_ready", W'(a_ready), W'(1));
      chk("cont0_m_ready", W'(m_ready), '0);
      cycle(1'b0, 1'b0, '0, '0, 1'b1, 5'd6, 32'h2222_2222, '0, '0);
      chk("cont1_m_ready", W'(m_ready), W'(1));
      chk("cont1_wen", W'(RegWEn), W'(1));
      chk("cont1_rsW", W'(rsW), W'(5));
      chk("cont1_rd", rd, 32'h1111_1111);
      idle('0, '0);
      chk("cont2_wen", W'(RegWEn), W'(1));
      chk("cont2_rsW", W'(rsW), W'(6));
      chk("cont2_rd", rd, 32'h2222_2222);

      // Round-robin fairness with both requesters always valid
      ga = 0; gm = 0;
      for (int i = 0; i < 8; i++) begin
         cycle(1'b0, 1'b1, S'($urandom_range(1, 31)), $urandom(),
               1'b1, S'($urandom_range(1, 31)), $urandom(), '0, '0);
         chk("rr_turn_a", W'(last_af), W'(i % 2 == 0));
         ga += int'(last_af);
         gm += int'(last_mf);
      end
      chk("rr_a_grants", W'(ga), W'(4));
      chk("rr_m_grants", W'(gm), W'(4));
      idle('0, '0);

      // Hazard tracking through acceptance and the write cycle
      cycle(1'b0, 1'b1, 5'd7, 32'h7777_0007, 1'b0, '0, '0, 5'd7, 5'd0);
      chk("haz_rs1_req", W'(rs1_pending), W'(1));
      chk("haz_rs2_zero", W'(rs2_pending), '0);
      idle(5'd7, 5'd0);
      chk("haz_rs1_wen", W'(rs1_pending), W'(1));
      idle(5'd7, 5'd0);
      chk("haz_rs1_clear", W'(rs1_pending), '0);
      cycle(1'b0, 1'b1, 5'd0, 32'h1234_5678, 1'b0, '0, '0, 5'd0, 5'd0);
      chk("haz_x0", W'(rs1_pending), '0);
      idle('0, '0);

      // Randomized traffic honouring the hold-until-accepted rule
      av = 1'b0; mv = 1'b0; as = '0; ms = '0; ad = '0; md = '0;
      for (int n = 0; n < 1500; n++) begin
         if (!av) begin
            av = ($urandom_range(0, 3) != 0);
            as = S'($urandom_range(0, 7));
            ad = $urandom();
         end
         if (!mv) begin
            mv = ($urandom_range(0, 3) != 0);
            ms = S'($urandom_range(0, 7));
            md = $urandom();
         end
         r = ($urandom_range(0, 49) == 0);
         cycle(r, av, as, ad, mv, ms, md, S'($urandom_range(0, 7)), S'($urandom_range(0, 7)));
         if (last_af) av = 1'b0;
         if (last_mf) mv = 1'b0;
      end
      idle('0, '0);
      idle('0, '0);
      idle('0, '0);

      // Final register-file contents: last accepted surviving write per index
      for (int i = 0; i < int'(NREG); i++) begin
         chk($sformatf("rf[%0d]", i), rf_dut[i], rf_exp[i]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
